// File: rtl/dzcpu_useq.sv
// Microcode sequencer: steps a micro-PC through ucode flows, tracks the macro PC,
// handles micro-calls/returns, memory stalls and interrupt entry between flows.
module dzcpu_useq #(
    parameter int                 UADDR_W     = 8,
    parameter int                 UOP_W       = 12,
    parameter int                 PC_W        = 16,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [UADDR_W-1:0] IRQ_FLOW    = 8'hF0
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [UOP_W-1:0]   iUop,
    input  logic [UADDR_W-1:0] iFlowIdx,
    input  logic [UADDR_W-1:0] iCbFlowIdx,
    input  logic [7:0]         iFlags,
    input  logic               iMemBusy,
    input  logic               iIrq,
    input  logic               iPcLoad,
    input  logic [PC_W-1:0]    iPcData,
    output logic [UADDR_W-1:0] oUpc,
    output logic [PC_W-1:0]    oPc,
    output logic               oFlowEnable,
    output logic               oIrqAck,
    output logic               oStackErr
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [3:0] CMD_JCB   = 4'hA;
    localparam logic [3:0] CMD_UCALL = 4'hB;
    localparam logic [3:0] CMD_URET  = 4'hC;
    localparam logic [3:0] CMD_EI    = 4'hD;
    localparam logic [3:0] CMD_DI    = 4'hE;

    typedef enum logic [2:0] {
        S_AFTER_RESET,
        S_START_FLOW,
        S_RUN_FLOW,
        S_WAIT_MEM,
        S_END_FLOW,
        S_IRQ_ENTRY
    } state_t;

    state_t               state_q, state_d;
    logic [UADDR_W-1:0]   upc_q, upc_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 ime_q, ime_d;
    logic [SP_W-1:0]      sp_q, sp_d;
    logic                 err_q, err_d;
    logic [UADDR_W-1:0]   stack_q [STACK_DEPTH];
    logic [UADDR_W-1:0]   stack_d [STACK_DEPTH];

    logic                 uop_ipc;
    logic [2:0]           uop_end;
    logic [3:0]           uop_cmd;
    logic [3:0]           uop_opd;
    logic                 end_true;
    logic                 exec;
    logic                 redirect;
    logic [UADDR_W-1:0]   target;
    logic [UADDR_W-1:0]   upc_inc;
    logic [SP_W-1:0]      sp_dec;
    logic [7:0]           call_addr;
    logic                 unused_bits;

    assign uop_ipc   = iUop[11];
    assign uop_end   = iUop[10:8];
    assign uop_cmd   = iUop[7:4];
    assign uop_opd   = iUop[3:0];
    assign upc_inc   = upc_q + 1'b1;
    assign sp_dec    = sp_q - 1'b1;
    assign call_addr = {uop_opd, 4'b0000};
    assign unused_bits = ^{iUop, iFlags, sp_dec};

    // WAIT_MEM behaves like RUN_FLOW once the memory frees up, so the held uop runs immediately.
    assign exec = ((state_q == S_RUN_FLOW) || (state_q == S_WAIT_MEM)) && !iMemBusy;

    always_comb begin
        end_true = 1'b0;
        case (uop_end)
            3'b100:  end_true = 1'b1;
            3'b101:  end_true = iFlags[7];
            3'b110:  end_true = !iFlags[7];
            3'b111:  end_true = iFlags[4];
            default: end_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        upc_d    = upc_q;
        pc_d     = pc_q;
        ime_d    = ime_q;
        sp_d     = sp_q;
        err_d    = err_q;
        stack_d  = stack_q;
        redirect = 1'b0;
        target   = upc_inc;

        case (state_q)
            S_AFTER_RESET: state_d = S_START_FLOW;
            S_START_FLOW: begin
                upc_d   = iFlowIdx;
                state_d = S_RUN_FLOW;
            end
            S_RUN_FLOW, S_WAIT_MEM: begin
                if (iMemBusy) begin
                    state_d = S_WAIT_MEM;
                end else begin
                    if (uop_ipc) pc_d = pc_q + 1'b1;
                    case (uop_cmd)
                        CMD_JCB: begin
                            redirect = 1'b1;
                            target   = iCbFlowIdx;
                        end
                        CMD_UCALL: begin
                            redirect = 1'b1;
                            target   = UADDR_W'(call_addr);
                            if (sp_q == SP_W'(STACK_DEPTH)) begin
                                err_d = 1'b1;
                            end else begin
                                stack_d[sp_q[IDX_W-1:0]] = upc_inc;
                                sp_d = sp_q + 1'b1;
                            end
                        end
                        CMD_URET: begin
                            redirect = 1'b1;
                            if (sp_q == '0) begin
                                err_d  = 1'b1;
                                target = '0;
                            end else begin
                                target = stack_q[sp_dec[IDX_W-1:0]];
                                sp_d   = sp_dec;
                            end
                        end
                        CMD_EI:  ime_d = 1'b1;
                        CMD_DI:  ime_d = 1'b0;
                        default: redirect = 1'b0;
                    endcase
                    // An ending uop keeps its stack/IME side effects but never redirects.
                    if (end_true) begin
                        state_d = S_END_FLOW;
                        upc_d   = upc_inc;
                    end else begin
                        state_d = S_RUN_FLOW;
                        upc_d   = redirect ? target : upc_inc;
                    end
                end
            end
            S_END_FLOW: state_d = (iIrq && ime_q) ? S_IRQ_ENTRY : S_START_FLOW;
            S_IRQ_ENTRY: begin
                ime_d   = 1'b0;
                sp_d    = '0;
                upc_d   = IRQ_FLOW;
                state_d = S_RUN_FLOW;
            end
            default: state_d = S_AFTER_RESET;
        endcase

        if (iPcLoad) pc_d = iPcData;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= S_AFTER_RESET;
            upc_q   <= '0;
            pc_q    <= '0;
            ime_q   <= 1'b0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            pc_q    <= pc_d;
            ime_q   <= ime_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            always_ff @(posedge iClock or negedge iReset) begin
                if (!iReset) stack_q[gi] <= '0;
                else         stack_q[gi] <= stack_d[gi];
            end
        end
    endgenerate

    assign oUpc        = upc_q;
    assign oPc         = pc_q;
    assign oFlowEnable = exec;
    assign oIrqAck     = (state_q == S_IRQ_ENTRY);
    assign oStackErr   = err_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq: per-cycle expectations are queued by the stimulus
// process and checked by an independent monitor on the falling edge.
module tb_dzcpu_useq;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [11:0] iUop;
    logic [7:0]  iFlowIdx;
    logic [7:0]  iCbFlowIdx;
    logic [7:0]  iFlags;
    logic        iMemBusy;
    logic        iIrq;
    logic        iPcLoad;
    logic [15:0] iPcData;
    logic [7:0]  oUpc;
    logic [15:0] oPc;
    logic        oFlowEnable;
    logic        oIrqAck;
    logic        oStackErr;

    logic [11:0] rom [256];

    typedef struct {
        string nm;
        int    upc;
        int    pc;
        int    fe;
        int    ack;
        int    err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 iClock = ~iClock;

    assign iUop = rom[oUpc];

    dzcpu_useq dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iUop        (iUop),
        .iFlowIdx    (iFlowIdx),
        .iCbFlowIdx  (iCbFlowIdx),
        .iFlags      (iFlags),
        .iMemBusy    (iMemBusy),
        .iIrq        (iIrq),
        .iPcLoad     (iPcLoad),
        .iPcData     (iPcData),
        .oUpc        (oUpc),
        .oPc         (oPc),
        .oFlowEnable (oFlowEnable),
        .oIrqAck     (oIrqAck),
        .oStackErr   (oStackErr)
    );

    function automatic logic [11:0] mk(input logic ipc, input logic [2:0] e,
                                       input logic [3:0] c, input logic [3:0] o);
        return {ipc, e, c, o};
    endfunction

    // A negative expected value means "don't care" for that field.
    task automatic chk(input string nm, input string f, input int got, input int exp);
        if (exp >= 0) begin
            n_checks++;
            if (got != exp) begin
                n_fail++;
                $display("FAIL %s %s: got %0h expected %0h", nm, f, got, exp);
            end
        end
    endtask

    always @(negedge iClock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "oUpc",        int'(oUpc),        e.upc);
            chk(e.nm, "oPc",         int'(oPc),         e.pc);
            chk(e.nm, "oFlowEnable", int'(oFlowEnable), e.fe);
            chk(e.nm, "oIrqAck",     int'(oIrqAck),     e.ack);
            chk(e.nm, "oStackErr",   int'(oStackErr),   e.err);
            $display("cycle %-14s upc=%02h pc=%04h fe=%0b ack=%0b err=%0b",
                     e.nm, oUpc, oPc, oFlowEnable, oIrqAck, oStackErr);
        end
    end

    task automatic cyc(input string nm, input int upc, input int pc,
                       input int fe, input int ack, input int err);
        exp_t e;
        e.nm = nm; e.upc = upc; e.pc = pc; e.fe = fe; e.ack = ack; e.err = err;
        sb.push_back(e);
        @(posedge iClock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[8'h20] = mk(1'b1, 3'b000, 4'h0, 4'h0);
        rom[8'h21] = mk(1'b1, 3'b100, 4'h0, 4'h0);
        rom[8'h30] = mk(1'b0, 3'b000, 4'hA, 4'h0);
        rom[8'h80] = mk(1'b0, 3'b101, 4'h0, 4'h0);
        rom[8'h81] = mk(1'b0, 3'b101, 4'h0, 4'h0);
        rom[8'h40] = mk(1'b0, 3'b000, 4'hB, 4'h5);
        rom[8'h50] = mk(1'b0, 3'b000, 4'hC, 4'h0);
        rom[8'h41] = mk(1'b0, 3'b100, 4'h0, 4'h0);
        rom[8'h60] = mk(1'b0, 3'b000, 4'hB, 4'h9);
        rom[8'h90] = mk(1'b0, 3'b000, 4'hB, 4'hA);
        rom[8'hA0] = mk(1'b0, 3'b000, 4'hB, 4'hB);
        rom[8'hB0] = mk(1'b0, 3'b000, 4'hB, 4'hC);
        rom[8'hC0] = mk(1'b0, 3'b100, 4'hB, 4'hD);
        rom[8'h10] = mk(1'b0, 3'b000, 4'hD, 4'h0);
        rom[8'h11] = mk(1'b0, 3'b100, 4'h0, 4'h0);
        rom[8'hF0] = mk(1'b0, 3'b100, 4'h0, 4'h0);
        rom[8'h12] = mk(1'b1, 3'b100, 4'h0, 4'h0);

        iReset = 1'b0; iFlowIdx = '0; iCbFlowIdx = 8'h80; iFlags = '0;
        iMemBusy = 1'b0; iIrq = 1'b0; iPcLoad = 1'b0; iPcData = '0;
        @(posedge iClock); #1;
        cyc("reset", 0, 0, 0, 0, 0);
        iReset = 1'b1;
        cyc("after_reset", 0, 0, 0, 0, 0);

        // Basic flow: two IPC uops, the second ends the flow.
        iFlowIdx = 8'h20; cyc("t1_start", 0, 0, 0, 0, 0);
        cyc("t1_u20", 'h20, 0, 1, 0, 0);
        cyc("t1_u21", 'h21, 1, 1, 0, 0);
        cyc("t1_end", -1, 2, 0, 0, 0);
        iFlowIdx = 8'h21; cyc("t1_restart", -1, 2, 0, 0, 0);

        // Memory stall for three cycles on uop 21.
        iMemBusy = 1'b1; cyc("t2_busy0", 'h21, 2, 0, 0, 0);
        cyc("t2_busy1", 'h21, 2, 0, 0, 0);
        cyc("t2_busy2", 'h21, 2, 0, 0, 0);
        iMemBusy = 1'b0; cyc("t2_exec", 'h21, 2, 1, 0, 0);
        cyc("t2_end", -1, 3, 0, 0, 0);

        // JCB then conditional end on Z.
        iFlowIdx = 8'h30; cyc("t3_start", -1, 3, 0, 0, 0);
        cyc("t3_jcb", 'h30, 3, 1, 0, 0);
        cyc("t3_z0", 'h80, 3, 1, 0, 0);
        iFlags = 8'h80; cyc("t3_z1", 'h81, 3, 1, 0, 0);
        iFlags = 8'h00; cyc("t3_end", -1, 3, 0, 0, 0);

        // UCALL / URET, then five nested calls overflow a 4-deep stack.
        iFlowIdx = 8'h40; cyc("t4_start", -1, 3, 0, 0, 0);
        cyc("t4_call", 'h40, 3, 1, 0, 0);
        cyc("t4_u50", 'h50, 3, 1, 0, 0);
        cyc("t4_ret", 'h41, 3, 1, 0, 0);
        cyc("t4_end", -1, 3, 0, 0, 0);
        iFlowIdx = 8'h60; cyc("t4_nstart", -1, 3, 0, 0, 0);
        cyc("t4_n1", 'h60, 3, 1, 0, 0);
        cyc("t4_n2", 'h90, 3, 1, 0, 0);
        cyc("t4_n3", 'hA0, 3, 1, 0, 0);
        cyc("t4_n4", 'hB0, 3, 1, 0, 0);
        cyc("t4_n5", 'hC0, 3, 1, 0, 0);
        iIrq = 1'b1; cyc("t4_end_noime", -1, 3, 0, 0, 1);

        // Interrupt with IME clear is ignored; EI then end takes the interrupt.
        iFlowIdx = 8'h10; cyc("t5_start", -1, 3, 0, 0, 1);
        cyc("t5_ei", 'h10, 3, 1, 0, 1);
        cyc("t5_u11", 'h11, 3, 1, 0, 1);
        cyc("t5_end", -1, 3, 0, 0, 1);
        cyc("t5_ack", -1, 3, 0, 1, 1);
        cyc("t5_f0", 'hF0, 3, 1, 0, 1);
        cyc("t5_end2", -1, 3, 0, 0, 1);

        // PC load to FFFF, then an IPC uop wraps to 0000.
        iIrq = 1'b0; iFlowIdx = 8'h12; iPcLoad = 1'b1; iPcData = 16'hFFFF;
        cyc("t5_noack", -1, 3, 0, 0, 1);
        iPcLoad = 1'b0; cyc("t6_ipc", 'h12, 'hFFFF, 1, 0, 1);
        cyc("t6_end", -1, 0, 0, 0, 1);

        // Asynchronous reset mid-flow, then a fresh flow.
        iFlowIdx = 8'h13; cyc("t7_start", -1, 0, 0, 0, 1);
        cyc("t7_u13", 'h13, 0, 1, 0, 1);
        cyc("t7_u14", 'h14, 0, 1, 0, 1);
        iReset = 1'b0; cyc("t7_rst", 0, 0, 0, 0, 0);
        iReset = 1'b1; cyc("t7_after", 0, 0, 0, 0, 0);
        iFlowIdx = 8'h20; cyc("t7_restart", 0, 0, 0, 0, 0);
        cyc("t7_u20", 'h20, 0, 1, 0, 0);
        cyc("t7_u21", 'h21, 1, 1, 0, 0);

        @(negedge iClock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
